hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 5, register-index width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, stall-counter width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 64, memory-wait cycle limit before timeout.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, with reset asynchronous and active-high.
REQ-006 The block SHALL have ports id_rs1, id_rs2, input, REG_WIDTH, source registers of the instruction in ID.
REQ-007 The block SHALL have ports ex_rs1, ex_rs2, ex_rd, input, REG_WIDTH, plus ex_reg_write (1) and ex_result_src (2), for the instruction in EX.
REQ-008 The block SHALL have ports mem_rd (REG_WIDTH) and mem_reg_write (1), inputs, for the instruction held in the EX/MEM register.
REQ-009 The block SHALL have ports wb_rd (REG_WIDTH) and wb_reg_write (1), inputs, for the instruction held in MEM/WB.
REQ-010 The block SHALL have port ex_pc_src, input, 1, taken branch/jump resolved in EX.
REQ-011 The block SHALL have ports mem_req and mem_ready, inputs, 1, data-memory access in MEM and its completion.
REQ-012 The block SHALL have outputs stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem (1 each), hold/clear enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-013 The block SHALL have outputs fwd_a and fwd_b, 2 bits, ALU operand forwarding selects.
REQ-014 The block SHALL have outputs state (2), stall_count (CNT_WIDTH), and mem_timeout (1).

Function
REQ-015 FSM states SHALL be RUN=00, LU_STALL=01, MEM_WAIT=10; 11 unreachable, treated as RUN.
REQ-016 Stall/flush/forward outputs SHALL be combinational from current state and inputs; state, counters, and mem_timeout SHALL be registered.
REQ-017 Memory stall: mem_req=1 and mem_ready=0 SHALL assert stall_if, stall_id, stall_ex, and bubble_mem, deassert both flushes, and next state MEM_WAIT; this has top priority in every state.
REQ-018 In MEM_WAIT with mem_ready=1: no memory stall that cycle; next state RUN.
REQ-019 Branch flush: ex_pc_src=1 with no memory stall SHALL assert flush_id and flush_ex, and suppress any load-use stall; a branch during MEM_WAIT is applied in the cycle mem_ready rises.
REQ-020 Load-use: in RUN with ex_result_src=01, ex_reg_write=1, ex_rd!=0, ex_rd equal to id_rs1 or id_rs2, and no higher-priority event, the block SHALL assert stall_if, stall_id, flush_ex; next state LU_STALL.
REQ-021 LU_STALL SHALL last exactly one cycle, with no load-use check in that cycle, then return to RUN; memory stall and branch still apply.
REQ-022 Forwarding fwd_a SHALL be 10 if mem_reg_write, mem_rd!=0, and mem_rd==ex_rs1; else 01 if the same holds for wb_rd; else 00; fwd_b likewise for ex_rs2; MEM wins over WB.
REQ-023 stall_count SHALL increment by 1 each cycle stall_if=1 and saturate at all-ones.
REQ-024 A wait counter SHALL count consecutive MEM_WAIT cycles; on reaching MAX_WAIT, mem_timeout SHALL set sticky until reset; stalling continues regardless.
REQ-025 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-026 rst=1 SHALL immediately force state=RUN, stall_count=0, wait counter=0, mem_timeout=0, regardless of clk.
REQ-027 Reset asserted mid-MEM_WAIT SHALL abort the wait; after deassertion the FSM evaluates from RUN.

Verification
REQ-028 The bench SHALL cover a load-use hazard: ex_result_src=01, ex_rd=5, id_rs1=5 -> stall_if=stall_id=flush_ex=1 for one cycle; state RUN->LU_STALL->RUN; stall_count=1.
REQ-029 The bench SHALL cover load-use on x0: ex_rd=0, id_rs2=0 -> no stall.
REQ-030 The bench SHALL cover a memory wait: mem_req=1 with mem_ready low for 3 cycles -> stall_ex=bubble_mem=1 for 3 cycles; RUN on the 4th cycle; stall_count=3.
REQ-031 The bench SHALL cover simultaneous events: ex_pc_src=1 plus a load-use match -> flush_id=flush_ex=1 and stall_if=0; the same with a memory stall -> stall only, flush after mem_ready.
REQ-032 The bench SHALL cover forwarding priority: mem_rd=wb_rd=ex_rs1=7, both write enables set -> fwd_a=10; mem_reg_write=0 -> fwd_a=01.
REQ-033 The bench SHALL cover timeout and reset: mem_ready low for 64 cycles -> mem_timeout=1 and it stays set; rst pulse -> mem_timeout=0 and state=RUN without a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
//   Detects load-use hazards, memory-wait stalls and taken-branch flushes,
//   and selects ALU operand forwarding sources.
// Ports:
//   clk, rst                 clock, async active-high reset
//   id_rs1/id_rs2            sources of the instruction in ID
//   ex_rs1/ex_rs2/ex_rd      registers of the instruction in EX
//   ex_reg_write             EX instruction writes a register
//   ex_result_src            EX result source (2'b01 = load)
//   mem_rd/mem_reg_write     destination held in EX/MEM
//   wb_rd/wb_reg_write       destination held in MEM/WB
//   ex_pc_src                taken branch/jump resolved in EX
//   mem_req/mem_ready        data-memory access in MEM and its completion
//   stall_if/stall_id/stall_ex  hold PC, IF/ID, ID/EX
//   flush_id/flush_ex        clear IF/ID, ID/EX
//   bubble_mem               insert bubble into MEM/WB
//   fwd_a/fwd_b              operand select: 10 = EX/MEM, 01 = MEM/WB, 00 = regfile
//   state                    FSM state (00 RUN, 01 LU_STALL, 10 MEM_WAIT)
//   stall_count              saturating count of cycles with stall_if
//   mem_timeout              sticky: memory wait reached MAX_WAIT cycles
module hazard_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_WAIT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] id_rs1,
  input  logic [REG_WIDTH-1:0] id_rs2,
  input  logic [REG_WIDTH-1:0] ex_rs1,
  input  logic [REG_WIDTH-1:0] ex_rs2,
  input  logic [REG_WIDTH-1:0] ex_rd,
  input  logic                 ex_reg_write,
  input  logic [1:0]           ex_result_src,
  input  logic [REG_WIDTH-1:0] mem_rd,
  input  logic                 mem_reg_write,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic                 wb_reg_write,
  input  logic                 ex_pc_src,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 bubble_mem,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 mem_timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t          st_q, st_d;
  logic [WW-1:0]   wait_cnt;
  logic            mem_stall, branch, lu_hit, lu_stall, in_run;

  assign state = st_q;

  // The unused encoding 11 behaves like RUN.
  assign in_run = (st_q != LU_STALL) && (st_q != MEM_WAIT);

  // Priority: memory stall > branch flush > load-use.
  assign mem_stall = mem_req & ~mem_ready;
  assign branch    = ex_pc_src & ~mem_stall;
  assign lu_hit    = (ex_result_src == 2'b01) && ex_reg_write &&
                     (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // The cycle after a load-use stall the load has moved on, so no re-check.
  assign lu_stall  = in_run && lu_hit && !mem_stall && !ex_pc_src;

  assign stall_if   = mem_stall | lu_stall;
  assign stall_id   = mem_stall | lu_stall;
  assign stall_ex   = mem_stall;
  assign bubble_mem = mem_stall;
  assign flush_id   = branch;
  assign flush_ex   = branch | lu_stall;

  always_comb begin
    st_d = RUN;
    if (mem_stall)     st_d = MEM_WAIT;
    else if (lu_stall) st_d = LU_STALL;
  end

  // Forwarding: the younger producer (EX/MEM) wins; x0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))     fwd_a = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))   fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))     fwd_b = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))   fwd_b = 2'b01;
  end

  // wait_cnt counts consecutive cycles the pipeline is held for memory
  // (each one lands in MEM_WAIT); it saturates so the compare stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= RUN;
      stall_count <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      st_q <= st_d;
      if (stall_if && (stall_count != {CNT_WIDTH{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (mem_stall) begin
        if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WW'(MAX_WAIT - 1)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_pc_src, mem_req, mem_ready;
  logic [1:0] ex_result_src;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mem_timeout;
  logic [1:0] fwd_a, fwd_b, state;
  logic [15:0] stall_count;

  hazard_ctrl #(.REG_WIDTH(5), .CNT_WIDTH(16), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_pc_src(ex_pc_src), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
    .flush_ex(flush_ex), .bubble_mem(bubble_mem), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // ctl = {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_MEM  = 6'b111001;
  localparam logic [1:0] S_RUN = 2'b00, S_LU = 2'b01, S_MW = 2'b10;

  typedef struct {
    string      nm;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_pc_src, mem_req, mem_ready;
    logic [1:0] ex_result_src;
    logic [5:0] ctl;
    logic [1:0] fa, fb, nst;
  } vec_t;

  typedef struct {
    string      nm;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t hz(input string nm, input logic [4:0] i1, input logic [4:0] i2,
                              input logic [4:0] rd, input logic rw, input logic [1:0] src,
                              input logic pcs, input logic mreq, input logic mrdy,
                              input logic [5:0] ctl, input logic [1:0] nst);
    vec_t v;
    v = '{nm: nm, default: '0};
    v.id_rs1 = i1; v.id_rs2 = i2; v.ex_rd = rd; v.ex_reg_write = rw; v.ex_result_src = src;
    v.ex_pc_src = pcs; v.mem_req = mreq; v.mem_ready = mrdy; v.ctl = ctl; v.nst = nst;
    return v;
  endfunction

  function automatic vec_t fw(input string nm, input logic [4:0] e1, input logic [4:0] e2,
                              input logic [4:0] mrd, input logic mwe, input logic [4:0] wrd,
                              input logic wwe, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v = '{nm: nm, default: '0};
    v.ex_rs1 = e1; v.ex_rs2 = e2; v.mem_rd = mrd; v.mem_reg_write = mwe;
    v.wb_rd = wrd; v.wb_reg_write = wwe; v.fa = fa; v.fb = fb; v.nst = S_RUN;
    return v;
  endfunction

  // Drive inputs and push the expected combinational response.
  task automatic drive(input vec_t v);
    exp_t e;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
    ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
    ex_reg_write = v.ex_reg_write; mem_reg_write = v.mem_reg_write;
    wb_reg_write = v.wb_reg_write; ex_pc_src = v.ex_pc_src;
    mem_req = v.mem_req; mem_ready = v.mem_ready; ex_result_src = v.ex_result_src;
    e.nm = v.nm; e.ctl = v.ctl; e.fa = v.fa; e.fb = v.fb;
    q.push_back(e);
  endtask

  // At the falling edge, pop the oldest expectation and compare.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk({e.nm, ".ctl"}, {26'd0, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem},
        {26'd0, e.ctl});
    chk({e.nm, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
    chk({e.nm, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
  endtask

  task automatic edge_state(input string nm, input logic [1:0] st);
    @(posedge clk); #1;
    chk({nm, ".state"}, {30'd0, state}, {30'd0, st});
  endtask

  // Asynchronous pulse placed away from clock edges.
  task automatic pulse_rst();
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  initial begin
    vec_t v, lu, mw;
    rst = 1'b1;
    drive(hz("init", 0, 0, 0, 0, 2'b00, 0, 0, 0, C_NONE, S_RUN));
    void'(q.pop_front());
    #12;
    chk("reset.state", {30'd0, state}, 32'd0);
    chk("reset.stall_count", {16'd0, stall_count}, 32'd0);
    chk("reset.mem_timeout", {31'd0, mem_timeout}, 32'd0);
    rst = 1'b0;

    tbl[0]  = hz("idle",        0, 0, 0, 0, 2'b00, 0, 0, 0, C_NONE, S_RUN);
    tbl[1]  = hz("lu_rs1",      5, 0, 5, 1, 2'b01, 0, 0, 0, C_LU,   S_LU);
    tbl[2]  = hz("lu_x0",       0, 0, 0, 1, 2'b01, 0, 0, 0, C_NONE, S_RUN);
    tbl[3]  = hz("nonload",     0, 5, 5, 1, 2'b00, 0, 0, 0, C_NONE, S_RUN);
    tbl[4]  = hz("lu_nowrite",  0, 5, 5, 0, 2'b01, 0, 0, 0, C_NONE, S_RUN);
    tbl[5]  = hz("br_over_lu",  5, 0, 5, 1, 2'b01, 1, 0, 0, C_BR,   S_RUN);
    tbl[6]  = hz("mem_over_br", 5, 0, 5, 1, 2'b01, 1, 1, 0, C_MEM,  S_MW);
    tbl[7]  = hz("mem_ready",   9, 6, 6, 1, 2'b01, 0, 1, 1, C_LU,   S_LU);
    tbl[8]  = fw("fwd_mem_win", 7, 0, 7, 1, 7, 1, 2'b10, 2'b00);
    tbl[9]  = fw("fwd_wb",      7, 0, 7, 0, 7, 1, 2'b01, 2'b00);
    tbl[10] = fw("fwd_x0",      0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    tbl[11] = fw("fwd_b_mem",   0, 3, 3, 1, 8, 1, 2'b00, 2'b10);
    tbl[12] = fw("fwd_split",   4, 9, 4, 1, 9, 1, 2'b10, 2'b01);

    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      pulse_rst();
      drive(tbl[i]);
      sample();
      edge_state(tbl[i].nm, tbl[i].nst);
    end

    // Load-use: one stall cycle, LU_STALL skips the check, count = 1.
    pulse_rst();
    lu = hz("seq_lu", 5, 0, 5, 1, 2'b01, 0, 0, 0, C_LU, S_LU);
    drive(lu); sample(); edge_state("seq_lu.c1", S_LU);
    lu.ctl = C_NONE; lu.nm = "seq_lu.hold";
    drive(lu); sample(); edge_state("seq_lu.c2", S_RUN);
    chk("seq_lu.stall_count", {16'd0, stall_count}, 32'd1);

    // Memory wait of 3 cycles, then ready.
    pulse_rst();
    mw = hz("seq_mw", 0, 0, 0, 0, 2'b00, 0, 1, 0, C_MEM, S_MW);
    for (int i = 0; i < 3; i++) begin
      drive(mw); sample(); edge_state("seq_mw.wait", S_MW);
    end
    mw.mem_ready = 1'b1; mw.ctl = C_NONE; mw.nm = "seq_mw.ready";
    drive(mw); sample(); edge_state("seq_mw.done", S_RUN);
    chk("seq_mw.stall_count", {16'd0, stall_count}, 32'd3);

    // Branch + load-use during memory stall: stall first, flush once ready.
    pulse_rst();
    v = hz("seq_brmem", 5, 0, 5, 1, 2'b01, 1, 1, 0, C_MEM, S_MW);
    drive(v); sample(); edge_state("seq_brmem.c1", S_MW);
    v.mem_ready = 1'b1; v.ctl = C_BR; v.nm = "seq_brmem.ready";
    drive(v); sample(); edge_state("seq_brmem.c2", S_RUN);

    // Timeout at 64 consecutive wait cycles, sticky, cleared by async reset.
    pulse_rst();
    mw = hz("seq_to", 0, 0, 0, 0, 2'b00, 0, 1, 0, C_MEM, S_MW);
    drive(mw); void'(q.pop_front());
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (i == 63) chk("timeout.at63", {31'd0, mem_timeout}, 32'd0);
      if (i == 64) chk("timeout.at64", {31'd0, mem_timeout}, 32'd1);
    end
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout.sticky", {31'd0, mem_timeout}, 32'd1);
    chk("timeout.state_run", {30'd0, state}, 32'd0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("timeout.rewait", {30'd0, state}, {30'd0, S_MW});
    #1 rst = 1'b1;
    #1;
    chk("async_rst.state", {30'd0, state}, 32'd0);
    chk("async_rst.timeout", {31'd0, mem_timeout}, 32'd0);
    chk("async_rst.stall_count", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;
    lu = hz("post_rst_lu", 5, 0, 5, 1, 2'b01, 0, 0, 0, C_LU, S_LU);
    drive(lu); sample(); edge_state("post_rst_lu", S_LU);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
